// File: rtl/oam_dma_engine.sv
// OAM DMA engine: copies one LEN-byte source page into the OAM, starting at a latched
// destination index, while holding the CPU stalled.
module oam_dma_engine #(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 8,
   parameter int                LEN       = 256,
   parameter logic [ADDR_W-1:0] TRIG_ADDR = 16'h4014,
   parameter bit                ALIGN_EN  = 1'b1
) (
   input  logic                   CLK,
   input  logic                   RESET_n,
   input  logic                   ENABLE,
   input  logic [ADDR_W-1:0]      CPU_ADDR,
   input  logic [DATA_W-1:0]      CPU_DATA,
   input  logic                   CPU_RW_n,
   input  logic [$clog2(LEN)-1:0] DEST_BASE,
   input  logic                   ABORT,
   output logic                   CPU_HALT,
   output logic [ADDR_W-1:0]      DMA_ADDR,
   output logic                   DMA_RDEN,
   input  logic [DATA_W-1:0]      DMA_RDATA,
   output logic                   DMA_WRITE,
   output logic [$clog2(LEN)-1:0] DMA_WADDR,
   output logic [DATA_W-1:0]      DMA_WDATA,
   output logic                   DMA_ACTIVE,
   output logic                   DMA_DONE
);

   localparam int IDX_W  = $clog2(LEN);
   localparam int PAGE_W = ADDR_W - IDX_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HALT  = 3'd1,
      ST_ALIGN = 3'd2,
      ST_READ  = 3'd3,
      ST_WRITE = 3'd4
   } state_t;

   state_t              state_r;
   logic                parity_r;
   logic [PAGE_W-1:0]   page_r;
   logic [IDX_W-1:0]    base_r;
   logic [IDX_W-1:0]    idx_r;

   logic                trigger_s;
   logic                last_s;
   logic [PAGE_W-1:0]   page_in_s;

   logic                busy_s;
   logic                rden_s;
   logic [ADDR_W-1:0]   addr_s;
   logic                write_s;
   logic [IDX_W-1:0]    waddr_s;
   logic [DATA_W-1:0]   wdata_s;
   logic                done_s;

   // The CPU's odd/even bus cycle marker simply flips on every enabled tick.
   function automatic logic parity_next(input logic cur);
      return ~cur;
   endfunction

   // Page number is the CPU data byte fitted to the page field width.
   generate
      if (DATA_W >= PAGE_W) begin : g_page_trunc
         assign page_in_s = CPU_DATA[PAGE_W-1:0];
      end else begin : g_page_zext
         assign page_in_s = {{(PAGE_W-DATA_W){1'b0}}, CPU_DATA};
      end
   endgenerate

   // Trigger decode and last-byte detect.
   always_comb begin
      trigger_s = 1'b0;
      last_s    = 1'b0;
      if ((state_r == ST_IDLE) && !CPU_RW_n && (CPU_ADDR == TRIG_ADDR)) begin
         trigger_s = 1'b1;
      end else begin
         trigger_s = 1'b0;
      end
      if (idx_r == IDX_LAST) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
   end

   // Transfer FSM with parity, page, base and index; everything holds while ENABLE is low.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_r  <= ST_IDLE;
         parity_r <= 1'b0;
         page_r   <= {PAGE_W{1'b0}};
         base_r   <= {IDX_W{1'b0}};
         idx_r    <= {IDX_W{1'b0}};
      end else if (ENABLE) begin
         parity_r <= parity_next(parity_r);
         case (state_r)
            ST_IDLE: begin
               // ABORT has no meaning here, so a coincident trigger always wins.
               if (trigger_s) begin
                  page_r  <= page_in_s;
                  base_r  <= DEST_BASE;
                  idx_r   <= {IDX_W{1'b0}};
                  state_r <= ST_HALT;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_HALT: begin
               if (ABORT) begin
                  state_r <= ST_IDLE;
               end else if (ALIGN_EN && parity_r) begin
                  state_r <= ST_ALIGN;
               end else begin
                  state_r <= ST_READ;
               end
            end
            ST_ALIGN: begin
               if (ABORT) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_READ;
               end
            end
            ST_READ: begin
               if (ABORT) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // The write strobed this cycle lands regardless; only the follow-on is cancelled.
               if (ABORT || last_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  idx_r   <= idx_r + IDX_ONE;
                  state_r <= ST_READ;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Moore output decode from the registered state; strobes are masked on idle ticks.
   always_comb begin
      busy_s  = 1'b0;
      rden_s  = 1'b0;
      addr_s  = {ADDR_W{1'b0}};
      write_s = 1'b0;
      waddr_s = {IDX_W{1'b0}};
      wdata_s = {DATA_W{1'b0}};
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            busy_s = 1'b0;
         end
         ST_HALT, ST_ALIGN: begin
            busy_s = 1'b1;
         end
         ST_READ: begin
            busy_s = 1'b1;
            rden_s = ENABLE;
            addr_s = {page_r, idx_r};
         end
         ST_WRITE: begin
            busy_s  = 1'b1;
            write_s = ENABLE;
            waddr_s = base_r + idx_r;
            wdata_s = DMA_RDATA;
            done_s  = ENABLE & last_s & ~ABORT;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   assign CPU_HALT   = busy_s;
   assign DMA_ACTIVE = busy_s;
   assign DMA_RDEN   = rden_s;
   assign DMA_ADDR   = addr_s;
   assign DMA_WRITE  = write_s;
   assign DMA_WADDR  = waddr_s;
   assign DMA_WDATA  = wdata_s;
   assign DMA_DONE   = done_s;

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine at default parameters, with a synchronous source RAM
// and a negedge monitor that logs strobes against enabled stall cycles.
module tb_oam_dma_engine;

   logic        CLK = 1'b0;
   logic        RESET_n;
   logic        ENABLE;
   logic [15:0] CPU_ADDR;
   logic [7:0]  CPU_DATA;
   logic        CPU_RW_n;
   logic [7:0]  DEST_BASE;
   logic        ABORT;
   logic        CPU_HALT;
   logic [15:0] DMA_ADDR;
   logic        DMA_RDEN;
   logic [7:0]  DMA_RDATA;
   logic        DMA_WRITE;
   logic [7:0]  DMA_WADDR;
   logic [7:0]  DMA_WDATA;
   logic        DMA_ACTIVE;
   logic        DMA_DONE;

   oam_dma_engine #(
      .ADDR_W(16), .DATA_W(8), .LEN(256), .TRIG_ADDR(16'h4014), .ALIGN_EN(1'b1)
   ) dut (
      .CLK(CLK), .RESET_n(RESET_n), .ENABLE(ENABLE), .CPU_ADDR(CPU_ADDR),
      .CPU_DATA(CPU_DATA), .CPU_RW_n(CPU_RW_n), .DEST_BASE(DEST_BASE), .ABORT(ABORT),
      .CPU_HALT(CPU_HALT), .DMA_ADDR(DMA_ADDR), .DMA_RDEN(DMA_RDEN), .DMA_RDATA(DMA_RDATA),
      .DMA_WRITE(DMA_WRITE), .DMA_WADDR(DMA_WADDR), .DMA_WDATA(DMA_WDATA),
      .DMA_ACTIVE(DMA_ACTIVE), .DMA_DONE(DMA_DONE)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] src_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   // Source RAM: data appears the cycle after the read strobe and holds otherwise.
   always @(posedge CLK) begin
      if (DMA_RDEN) DMA_RDATA <= src_byte(DMA_ADDR);
   end

   // Expected CPU parity: cleared by reset, flips on every enabled tick.
   logic par_m = 1'b0;
   always @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) par_m <= 1'b0;
      else if (ENABLE) par_m <= ~par_m;
   end

   int          stall_cnt = 0;
   int          off_strobe = 0;
   logic [15:0] rd_q[$];
   int          rd_t[$];
   logic [7:0]  wa_q[$];
   logic [7:0]  wd_q[$];
   int          done_t[$];

   // Log activity mid-cycle; stall cycles count only enabled ticks with the CPU held.
   always @(negedge CLK) begin
      if (ENABLE && CPU_HALT) stall_cnt = stall_cnt + 1;
      if (DMA_RDEN) begin
         rd_q.push_back(DMA_ADDR);
         rd_t.push_back(stall_cnt);
      end
      if (DMA_WRITE) begin
         wa_q.push_back(DMA_WADDR);
         wd_q.push_back(DMA_WDATA);
      end
      if (DMA_DONE) done_t.push_back(stall_cnt);
      if (!ENABLE && (DMA_RDEN || DMA_WRITE || DMA_DONE)) off_strobe = off_strobe + 1;
   end

   int n_chk = 0;
   int n_fail = 0;
   int snap_stall, snap_wr, snap_rd, snap_done, snap_off;
   logic exp_align;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic take_snap();
      snap_stall = stall_cnt;
      snap_wr    = wa_q.size();
      snap_rd    = rd_q.size();
      snap_done  = done_t.size();
      snap_off   = off_strobe;
   endtask

   task automatic wait_parity(input logic want);
      for (int i = 0; i < 4 && par_m !== want; i++) tick();
   endtask

   // One enabled trigger cycle; the HALT cycle then sees the flipped parity.
   task automatic do_trigger(input logic [7:0] page, input logic [7:0] base);
      take_snap();
      exp_align = ~par_m;
      CPU_ADDR  = 16'h4014;
      CPU_RW_n  = 1'b0;
      CPU_DATA  = page;
      DEST_BASE = base;
      tick();
      CPU_ADDR  = 16'h0000;
      CPU_RW_n  = 1'b1;
      CPU_DATA  = 8'h00;
      DEST_BASE = ~base;
   endtask

   task automatic run_until_idle(input bit toggle, input int budget);
      int i = 0;
      while (CPU_HALT && i < budget) begin
         if (toggle) ENABLE = ~ENABLE;
         tick();
         i++;
      end
      ENABLE = 1'b1;
      check_val("idle_within_budget", {31'd0, CPU_HALT}, 32'd0);
   endtask

   task automatic check_transfer(input string tag, input logic [7:0] page,
                                 input logic [7:0] base, input int exp_stall);
      int nw, nr, nd, bad_wa, bad_wd, bad_ra, first_rd, done_at;
      logic [7:0] k8;
      nw = wa_q.size() - snap_wr;
      nr = rd_q.size() - snap_rd;
      nd = done_t.size() - snap_done;
      bad_wa = 0; bad_wd = 0; bad_ra = 0;
      for (int k = 0; k < 256 && k < nw && k < nr; k++) begin
         k8 = 8'(k);
         if (wa_q[snap_wr+k] !== 8'(base + k8)) bad_wa++;
         if (wd_q[snap_wr+k] !== src_byte({page, k8})) bad_wd++;
         if (rd_q[snap_rd+k] !== {page, k8}) bad_ra++;
      end
      first_rd = (nr > 0) ? rd_t[snap_rd] - snap_stall : -1;
      done_at  = (nd > 0) ? done_t[snap_done] - snap_stall : -1;
      check_val({tag, "_writes"}, nw, 256);
      check_val({tag, "_reads"}, nr, 256);
      check_val({tag, "_waddr_bad"}, bad_wa, 0);
      check_val({tag, "_wdata_bad"}, bad_wd, 0);
      check_val({tag, "_raddr_bad"}, bad_ra, 0);
      check_val({tag, "_stall"}, stall_cnt - snap_stall, exp_stall);
      check_val({tag, "_done_cnt"}, nd, 1);
      check_val({tag, "_done_at"}, done_at, exp_stall);
      check_val({tag, "_first_rd"}, first_rd, exp_stall - 511);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rd_seen;
      int w_rst, d_rst;
      RESET_n = 1'b0; ENABLE = 1'b1; CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1;
      CPU_DATA = 8'h00; DEST_BASE = 8'h00; ABORT = 1'b0;
      tick(); tick();
      check_val("rst_halt", {31'd0, CPU_HALT}, 32'd0);
      check_val("rst_active", {31'd0, DMA_ACTIVE}, 32'd0);
      check_val("rst_rd", {15'd0, DMA_RDEN, DMA_ADDR}, 32'd0);
      check_val("rst_wr", {15'd0, DMA_WRITE, DMA_WADDR, DMA_WDATA}, 32'd0);
      check_val("rst_done", {31'd0, DMA_DONE}, 32'd0);
      #2 RESET_n = 1'b1;
      tick(); tick(); tick();

      // Basic page copy, no alignment stall.
      wait_parity(1'b1);
      do_trigger(8'h02, 8'h00);
      check_val("t1_halt_state", {30'd0, CPU_HALT, DMA_RDEN}, 32'h2);
      tick();
      check_val("t1_first_read", {15'd0, DMA_RDEN, DMA_ADDR}, {15'd0, 1'b1, 16'h0200});
      run_until_idle(1'b0, 700);
      check_transfer("t1", 8'h02, 8'h00, 513);

      // HALT on odd parity inserts one ALIGN cycle.
      wait_parity(1'b0);
      do_trigger(8'h02, 8'h00);
      tick();
      check_val("t2_align_state", {30'd0, CPU_HALT, DMA_RDEN}, 32'h2);
      tick();
      check_val("t2_first_read", {15'd0, DMA_RDEN, DMA_ADDR}, {15'd0, 1'b1, 16'h0200});
      run_until_idle(1'b0, 700);
      check_transfer("t2", 8'h02, 8'h00, 514);

      // Destination wrap from a high base index.
      do_trigger(8'h03, 8'hFC);
      run_until_idle(1'b0, 700);
      check_transfer("t3", 8'h03, 8'hFC, exp_align ? 514 : 513);
      if (wa_q.size() >= snap_wr + 256) begin
         check_val("t3_wa0", wa_q[snap_wr+0], 8'hFC);
         check_val("t3_wa3", wa_q[snap_wr+3], 8'hFF);
         check_val("t3_wa4", wa_q[snap_wr+4], 8'h00);
         check_val("t3_wa_last", wa_q[snap_wr+255], 8'hFB);
         check_val("t3_rd_last", rd_q[snap_rd+255], 16'h03FF);
         check_val("t3_wd_last", wd_q[snap_wr+255], src_byte(16'h03FF));
      end else begin
         check_val("t3_short", wa_q.size() - snap_wr, 256);
      end

      // ENABLE alternating every cycle: same result in enabled cycles, no strobes when off.
      wait_parity(1'b1);
      do_trigger(8'h02, 8'h00);
      run_until_idle(1'b1, 1400);
      check_transfer("t4", 8'h02, 8'h00, 513);
      check_val("t4_off_strobes", off_strobe - snap_off, 0);

      // Abort in the 10th READ.
      do_trigger(8'h04, 8'h00);
      rd_seen = 0;
      for (int i = 0; i < 200; i++) begin
         if (DMA_RDEN) rd_seen++;
         if (rd_seen == 10) break;
         tick();
      end
      check_val("t5_rd10_seen", rd_seen, 10);
      check_val("t5_rd10_addr", DMA_ADDR, 16'h0409);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      check_val("t5_abort_idle", {30'd0, CPU_HALT, DMA_ACTIVE}, 32'd0);
      tick(); tick(); tick();
      check_val("t5_abort_writes", wa_q.size() - snap_wr, 9);
      check_val("t5_abort_no_done", done_t.size() - snap_done, 0);

      // Trigger with coincident ABORT is accepted; a mid-transfer trigger write is ignored.
      ABORT = 1'b1;
      do_trigger(8'h05, 8'h10);
      ABORT = 1'b0;
      check_val("t6_trig_accepted", {31'd0, CPU_HALT}, 32'd1);
      repeat (20) tick();
      CPU_ADDR = 16'h4014; CPU_RW_n = 1'b0; CPU_DATA = 8'h07;
      tick();
      CPU_ADDR = 16'h0000; CPU_RW_n = 1'b1; CPU_DATA = 8'h00;
      check_val("t6_still_busy", {31'd0, CPU_HALT}, 32'd1);
      run_until_idle(1'b0, 700);
      check_transfer("t6", 8'h05, 8'h10, exp_align ? 514 : 513);

      // Reset asserted mid-transfer.
      do_trigger(8'h06, 8'h00);
      repeat (30) tick();
      #2 RESET_n = 1'b0;
      #1;
      check_val("t7_rst_outs", {DMA_ADDR, DMA_WADDR, DMA_RDEN, DMA_WRITE, DMA_DONE,
                                CPU_HALT, DMA_ACTIVE, 3'd0}, 32'd0);
      check_val("t7_rst_wdata", DMA_WDATA, 8'h00);
      w_rst = wa_q.size();
      d_rst = done_t.size();
      @(posedge CLK);
      #3 RESET_n = 1'b1;
      repeat (10) tick();
      check_val("t7_post_writes", wa_q.size() - w_rst, 0);
      check_val("t7_post_done", done_t.size() - d_rst, 0);
      check_val("t7_post_idle", {31'd0, CPU_HALT}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
